rf_context_ctrl: RTL and testbench

- Sequencer for the RF state chain: performs context save, restore or swap of all RF registers through the serial state-save path.
- Halts the array around the operation, drives the RF's iOldStateOut / iStateShift / iNewStateIn, and bridges the serial chain to an external context store with per-bit flow control.
- One instance per RF state chain, placed between the configuration/context manager and the RF.

---
 rtl/rf_context_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rf_context_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_context_ctrl.sv
// rf_context_ctrl: sequences a save, restore or swap of the RF state chain.
// The array is halted, the registers are snapshotted into the shadow chain,
// the chain is shifted bit-serially against an external context store (with
// per-bit flow control), and the shadow is optionally loaded back into the
// registers. One instance sits between the context manager and one RF chain.
module rf_context_ctrl #(
    parameter int STATE_LENGTH = 128,
    parameter int CNT_WIDTH    = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iReq,
    input  logic [1:0] iMode,
    output logic       oAck,
    output logic       oBusy,
    output logic       oDone,
    output logic       oHalt,
    output logic       oOldStateOut,
    output logic       oNewStateIn,
    output logic       oStateShift,
    output logic       oStateDataIn,
    input  logic       iStateDataOut,
    input  logic       iCtxData,
    input  logic       iCtxStall,
    output logic       oCtxData,
    output logic       oCtxValid
);

    // Mode encoding: bit0 = capture the live registers, bit1 = load new ones.
    localparam logic [1:0] MODE_NULL = 2'b00;

    // Final bit index of the chain and final drain cycle index.
    localparam logic [CNT_WIDTH-1:0] LAST_BIT   = CNT_WIDTH'(STATE_LENGTH - 1);
    localparam logic [3:0]           LAST_DRAIN = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SNAP,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    state_t               state;
    logic [1:0]           mode;
    logic [3:0]           drain_cnt;
    logic [CNT_WIDTH-1:0] bit_cnt;

    logic ack_q;
    logic busy_q;
    logic done_q;
    logic halt_q;
    logic snap_q;
    logic load_q;

    logic in_shift;
    logic shift_go;

    // A shift only happens while the context store is ready; a stalled
    // cycle moves nothing, so the chain and the store stay in lockstep.
    assign in_shift = (state == SHIFT);
    assign shift_go = in_shift & ~iCtxStall;

    // Sequencer: state transitions plus registered control strobes, which
    // are set on the edge that enters the state they belong to.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state     <= IDLE;
            mode      <= MODE_NULL;
            drain_cnt <= '0;
            bit_cnt   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            halt_q    <= 1'b0;
            snap_q    <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            snap_q <= 1'b0;
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq) begin
                        mode   <= iMode;
                        ack_q  <= 1'b1;
                        busy_q <= 1'b1;
                        if (iMode == MODE_NULL) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            halt_q    <= 1'b1;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        drain_cnt <= '0;
                        bit_cnt   <= '0;
                        if (mode[0]) begin
                            state  <= SNAP;
                            snap_q <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                SNAP: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (!iCtxStall) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (mode[1]) begin
                                state  <= LOAD;
                                load_q <= 1'b1;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    halt_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    halt_q <= 1'b0;
                end
            endcase
        end
    end

    assign oAck         = ack_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oHalt        = halt_q;
    assign oOldStateOut = snap_q;
    assign oNewStateIn  = load_q;

    // Serial datapath: restores feed the chain from the store, save-only
    // recirculates so the shadow ends up holding its snapshot again.
    assign oStateShift  = shift_go;
    assign oCtxValid    = shift_go;
    assign oStateDataIn = in_shift & (mode[1] ? iCtxData : iStateDataOut);
    assign oCtxData     = in_shift & iStateDataOut;

endmodule

// File: tb/tb_rf_context_ctrl.sv
// Directed testbench for rf_context_ctrl with a behavioural RF state chain
// and context store model around the DUT.
module tb_rf_context_ctrl;

   logic         clk = 1'b0;
   logic         resetN;
   logic         req;
   logic [1:0]   modeSel;
   logic         ack;
   logic         busy;
   logic         done;
   logic         halt;
   logic         oldStateOut;
   logic         newStateIn;
   logic         stateShift;
   logic         stateDataIn;
   logic         stateDataOut;
   logic         ctxRdData;
   logic         ctxStall;
   logic         ctxWrData;
   logic         ctxValid;

   // Behavioural RF and context store state
   logic [127:0] regs = '0;
   logic [127:0] shadow = '0;
   logic [127:0] captured = '0;
   logic [127:0] regsInit;
   logic [127:0] ctxImage;
   logic [7:0]   capIdx = '0;
   logic [6:0]   ctxIdx = '0;
   int           shiftCount = 0;
   int           doneCount = 0;
   logic         newSeen = 1'b0;
   logic         haltSeen = 1'b0;
   logic         strobeSeen = 1'b0;
   logic         clash = 1'b0;
   logic         clearReq;

   int           errors = 0;
   int           checks = 0;
   logic [9:0]   allOut;

   rf_context_ctrl #(
      .STATE_LENGTH(128),
      .CNT_WIDTH(8),
      .DRAIN_CYCLES(2)
   ) dut (
      .iClk(clk),
      .iReset(resetN),
      .iReq(req),
      .iMode(modeSel),
      .oAck(ack),
      .oBusy(busy),
      .oDone(done),
      .oHalt(halt),
      .oOldStateOut(oldStateOut),
      .oNewStateIn(newStateIn),
      .oStateShift(stateShift),
      .oStateDataIn(stateDataIn),
      .iStateDataOut(stateDataOut),
      .iCtxData(ctxRdData),
      .iCtxStall(ctxStall),
      .oCtxData(ctxWrData),
      .oCtxValid(ctxValid)
   );

   // Free-running clock, 10 ns period
   always #5 clk = ~clk;

   assign stateDataOut = shadow[0];
   assign ctxRdData    = ctxImage[ctxIdx];
   assign allOut = {ack, busy, done, halt, oldStateOut, newStateIn,
                    stateShift, stateDataIn, ctxWrData, ctxValid};

   // RF chain model: snapshot registers to shadow, shift LSB-first with the
   // new bit entering at the top, load shadow back; the store side captures
   // every valid save bit and advances its read pointer in step.
   always @(posedge clk) begin
      if (clearReq) begin
         regs       <= regsInit;
         captured   <= '0;
         capIdx     <= '0;
         ctxIdx     <= '0;
         shiftCount <= 0;
         doneCount  <= 0;
         newSeen    <= 1'b0;
         haltSeen   <= 1'b0;
         strobeSeen <= 1'b0;
      end else begin
         if (oldStateOut)
            shadow <= regs;
         else if (stateShift)
            shadow <= {stateDataIn, shadow[127:1]};
         if (newStateIn)
            regs <= shadow;
         if (ctxValid) begin
            captured[capIdx[6:0]] <= ctxWrData;
            capIdx <= capIdx + 8'd1;
            ctxIdx <= ctxIdx + 7'd1;
         end
         if (stateShift)
            shiftCount <= shiftCount + 1;
         if (done)
            doneCount <= doneCount + 1;
         if (newStateIn)
            newSeen <= 1'b1;
         if (halt)
            haltSeen <= 1'b1;
         if (stateShift | oldStateOut | newStateIn)
            strobeSeen <= 1'b1;
      end
      if (int'(oldStateOut) + int'(newStateIn) + int'(stateShift) > 1)
         clash <= 1'b1;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Load the RF model registers and reset the scoreboard counters
   task automatic prepare();
      clearReq = 1'b1;
      @(negedge clk);
      clearReq = 1'b0;
   endtask

   // From cycle 1 after accept: wait for oDone, optionally stalling every
   // third SHIFT cycle (SHIFT begins in cycle 3 when no snapshot is taken)
   task automatic waitDone(input bit stallEn, input logic [1:0] m,
                           output int latency);
      int k;
      k = 1;
      latency = -1;
      while (k <= 1000) begin
         ctxStall = stallEn && (k >= 3) && (((k - 3) % 3) == 2);
         if (done) begin
            latency = k;
            checkOutput("halt_in_done", halt, (m != 2'b00));
            break;
         end
         @(negedge clk);
         k++;
      end
      ctxStall = 1'b0;
   endtask

   // Issue one request and run it to completion
   task automatic applyStimulus(input logic [1:0] m, input bit stallEn,
                                input bit holdReq, output int latency);
      @(negedge clk);
      req = 1'b1;
      modeSel = m;
      @(negedge clk);
      if (!holdReq)
         req = 1'b0;
      checkOutput("ack_pulse", ack, 1'b1);
      checkOutput("busy_after_accept", busy, 1'b1);
      waitDone(stallEn, m, latency);
   endtask

   initial begin
      int lat;
      int lat2;
      logic [127:0] expImage;

      resetN = 1'b0;
      req = 1'b0;
      modeSel = 2'b00;
      ctxStall = 1'b0;
      clearReq = 1'b0;
      regsInit = '0;
      ctxImage = '0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("outputs_in_reset", allOut, '0);
      resetN = 1'b1;
      @(negedge clk);
      checkOutput("outputs_after_release", allOut, '0);

      // Swap: r[i]=i, context stream 0xA0+i
      for (int i = 0; i < 16; i++) begin
         regsInit[8*i +: 8] = 8'(i);
         ctxImage[8*i +: 8] = 8'(8'hA0 + i);
      end
      prepare();
      applyStimulus(2'b11, 1'b0, 1'b0, lat);
      checkOutput("swap_latency", lat, 133);
      checkOutput("swap_captured", captured, regsInit);
      checkOutput("swap_regs", regs, ctxImage);
      checkOutput("swap_shifts", shiftCount, 128);

      // Save-only: r[i]=0x11*i
      for (int i = 0; i < 16; i++)
         regsInit[8*i +: 8] = 8'(8'h11 * i);
      ctxImage = '0;
      prepare();
      applyStimulus(2'b01, 1'b0, 1'b0, lat);
      checkOutput("save_latency", lat, 132);
      checkOutput("save_captured", captured, regsInit);
      checkOutput("save_regs_unchanged", regs, regsInit);
      checkOutput("save_no_load", newSeen, 1'b0);
      checkOutput("save_shifts", shiftCount, 128);

      // Restore with a stall on every third SHIFT cycle: 63 stalls
      regsInit = '0;
      for (int i = 0; i < 16; i++)
         ctxImage[8*i +: 8] = 8'(8'h3C + 8'(i * 29));
      prepare();
      applyStimulus(2'b10, 1'b1, 1'b0, lat);
      checkOutput("restore_latency", lat, 195);
      checkOutput("restore_shifts", shiftCount, 128);
      checkOutput("restore_regs", regs, ctxImage);

      // Null request: ack and done together, no halt or strobes
      prepare();
      applyStimulus(2'b00, 1'b0, 1'b0, lat);
      checkOutput("null_latency", lat, 1);
      @(negedge clk);
      checkOutput("null_no_halt", haltSeen, 1'b0);
      checkOutput("null_no_strobes", strobeSeen, 1'b0);
      checkOutput("null_busy_clears", busy, 1'b0);

      // Reset at bit 60 of a swap aborts without oDone
      for (int i = 0; i < 16; i++) begin
         regsInit[8*i +: 8] = 8'(i);
         ctxImage[8*i +: 8] = 8'(8'hA0 + i);
      end
      prepare();
      req = 1'b1;
      modeSel = 2'b11;
      @(negedge clk);
      req = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (capIdx == 8'd60)
            break;
         @(negedge clk);
      end
      checkOutput("abort_reached_bit60", capIdx, 8'd60);
      resetN = 1'b0;
      #1;
      checkOutput("abort_outputs_zero", allOut, '0);
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      checkOutput("abort_first_cycle_zero", allOut, '0);
      repeat (5) @(negedge clk);
      checkOutput("abort_no_done", doneCount, 0);

      // Fresh swap after the abort
      prepare();
      applyStimulus(2'b11, 1'b0, 1'b0, lat);
      checkOutput("fresh_swap_latency", lat, 133);
      checkOutput("fresh_swap_captured", captured, regsInit);
      checkOutput("fresh_swap_regs", regs, ctxImage);

      // Request held high: back-to-back swaps with one IDLE cycle between
      prepare();
      applyStimulus(2'b11, 1'b0, 1'b1, lat);
      checkOutput("b2b_first_latency", lat, 133);
      @(negedge clk);
      checkOutput("b2b_idle_ack", ack, 1'b0);
      checkOutput("b2b_idle_busy", busy, 1'b0);
      @(negedge clk);
      checkOutput("b2b_reack", ack, 1'b1);
      req = 1'b0;
      waitDone(1'b0, 2'b11, lat2);
      checkOutput("b2b_second_latency", lat2, 133);
      expImage = ctxImage;
      checkOutput("b2b_regs", regs, expImage);
      @(negedge clk);
      checkOutput("strobes_exclusive", clash, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
